stream_downsizer: RTL and testbench

STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

---
 rtl/stream_downsizer.sv | 70 +++++++
 tb/tb_stream_downsizer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stream_downsizer.sv
// Width downsizer: splits each DW_OUT*SCALE-bit input word into SCALE output
// words, least-significant chunk first, at up to one output word per cycle.
module stream_downsizer #(
    parameter int DW_OUT = 16,
    parameter int SCALE  = 3,
    localparam int DW_IN = DW_OUT * SCALE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW_IN-1:0]  s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [DW_OUT-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i
);

    localparam int CW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCALE - 1);

    logic [DW_IN-1:0]  hold_reg;
    logic [CW-1:0]     cnt_reg;
    logic              full_reg;
    logic              last_chunk;
    logic              in_xfer;
    logic              out_xfer;
    logic [DW_OUT-1:0] chunk [SCALE];

    assign last_chunk = (cnt_reg == CNT_LAST);
    // A new word may enter in the same cycle the last chunk of the old one leaves.
    assign s_ready_o  = !full_reg || (m_ready_i && last_chunk);
    assign in_xfer    = s_valid_i && s_ready_o;
    assign out_xfer   = full_reg && m_ready_i;
    assign m_valid_o  = full_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg <= '0;
            cnt_reg  <= '0;
            full_reg <= 1'b0;
        end else if (in_xfer) begin
            hold_reg <= s_data_i;
            cnt_reg  <= '0;
            full_reg <= 1'b1;
        end else if (out_xfer) begin
            if (last_chunk) begin
                cnt_reg  <= '0;
                full_reg <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < SCALE; gi++) begin : g_chunk
            assign chunk[gi] = hold_reg[gi*DW_OUT +: DW_OUT];
        end
    endgenerate

    always_comb begin
        m_data_o = '0;
        for (int i = 0; i < SCALE; i++) begin
            if (cnt_reg == CW'(i)) begin
                m_data_o = chunk[i];
            end
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed and randomized checks of stream_downsizer with DW_OUT=16, SCALE=3.
module tb_stream_downsizer;

    localparam int DW_OUT = 16;
    localparam int SCALE  = 3;
    localparam int DW_IN  = DW_OUT * SCALE;
    localparam int N_RAND = 5461;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW_IN-1:0]  s_data_i = '0;
    logic              s_valid_i = 1'b0;
    logic              s_ready_o;
    logic [DW_OUT-1:0] m_data_o;
    logic              m_valid_o;
    logic              m_ready_i = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    stream_downsizer #(.DW_OUT(DW_OUT), .SCALE(SCALE)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW_OUT-1:0] exp_q [$];
    logic [DW_OUT-1:0] exp_word;
    int words_sent;
    int outs_seen;
    int cycles;
    logic in_x;
    logic out_x;

    initial begin
        // Reset state, observed before any clock edge
        #2;
        chk("rst_m_valid", 64'(m_valid_o), 64'd0);
        chk("rst_m_data",  64'(m_data_o),  64'd0);
        chk("rst_s_ready", 64'(s_ready_o), 64'd1);
        step();
        step();
        rst = 1'b0;

        // Single word, ready held high
        s_data_i  = 48'h3333_2222_1111;
        s_valid_i = 1'b1;
        m_ready_i = 1'b1;
        chk("single_s_ready_idle", 64'(s_ready_o), 64'd1);
        step();
        s_valid_i = 1'b0;
        chk("single_v0", 64'(m_valid_o), 64'd1);
        chk("single_d0", 64'(m_data_o), 64'h1111);
        chk("single_r0", 64'(s_ready_o), 64'd0);
        step();
        chk("single_d1", 64'(m_data_o), 64'h2222);
        chk("single_r1", 64'(s_ready_o), 64'd0);
        step();
        chk("single_d2", 64'(m_data_o), 64'h3333);
        chk("single_r2", 64'(s_ready_o), 64'd1);
        step();
        chk("single_done_v", 64'(m_valid_o), 64'd0);
        chk("single_done_r", 64'(s_ready_o), 64'd1);

        // Three back-to-back words carrying chunks 1..9
        s_data_i  = 48'h0003_0002_0001;
        s_valid_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 0) s_data_i = 48'h0006_0005_0004;
            if (k == 3) s_data_i = 48'h0009_0008_0007;
            if (k == 6) s_valid_i = 1'b0;
            chk($sformatf("b2b_v%0d", k), 64'(m_valid_o), 64'd1);
            chk($sformatf("b2b_d%0d", k), 64'(m_data_o), 64'(k + 1));
            chk($sformatf("b2b_r%0d", k), 64'(s_ready_o), 64'((k % 3) == 2));
        end
        step();
        chk("b2b_done_v", 64'(m_valid_o), 64'd0);

        // Backpressure while chunk 1 is presented; input changes must be ignored
        s_data_i  = 48'h3333_2222_1111;
        s_valid_i = 1'b1;
        step();
        s_valid_i = 1'b0;
        chk("stall_d0", 64'(m_data_o), 64'h1111);
        step();
        m_ready_i = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = 48'hDEAD_BEEF_F00D;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stall_hold_d%0d", k), 64'(m_data_o), 64'h2222);
            chk($sformatf("stall_hold_v%0d", k), 64'(m_valid_o), 64'd1);
            chk($sformatf("stall_hold_r%0d", k), 64'(s_ready_o), 64'd0);
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        step();
        chk("stall_resume_d2", 64'(m_data_o), 64'h3333);
        step();
        chk("stall_done_v", 64'(m_valid_o), 64'd0);

        // Reset mid-word discards the remaining chunks
        s_data_i  = 48'h3333_2222_1111;
        s_valid_i = 1'b1;
        step();
        s_valid_i = 1'b0;
        chk("midrst_d0", 64'(m_data_o), 64'h1111);
        step();
        chk("midrst_d1", 64'(m_data_o), 64'h2222);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_async_v", 64'(m_valid_o), 64'd0);
        chk("midrst_async_d", 64'(m_data_o), 64'd0);
        chk("midrst_async_r", 64'(s_ready_o), 64'd1);
        step();
        step();
        rst = 1'b0;
        s_data_i  = 48'hCCCC_BBBB_AAAA;
        s_valid_i = 1'b1;
        step();
        s_valid_i = 1'b0;
        chk("postrst_d0", 64'(m_data_o), 64'hAAAA);
        step();
        chk("postrst_d1", 64'(m_data_o), 64'hBBBB);
        step();
        chk("postrst_d2", 64'(m_data_o), 64'hCCCC);
        step();
        chk("postrst_done_v", 64'(m_valid_o), 64'd0);

        // Random stream with random valid/ready duty, checked against a queue
        words_sent = 0;
        outs_seen  = 0;
        cycles     = 0;
        s_valid_i  = 1'b0;
        while ((words_sent < N_RAND || exp_q.size() != 0) && cycles < 80000) begin
            if (!s_valid_i && words_sent < N_RAND && $urandom_range(0, 3) != 0) begin
                s_valid_i = 1'b1;
                s_data_i  = {16'($urandom), 32'($urandom)};
            end
            m_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rand_valid", 64'(m_valid_o), 64'(exp_q.size() != 0));
            in_x  = s_valid_i && s_ready_o;
            out_x = m_valid_o && m_ready_i;
            if (out_x && exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                chk("rand_data", 64'(m_data_o), 64'(exp_word));
                outs_seen++;
            end
            if (in_x) begin
                for (int c = 0; c < SCALE; c++) begin
                    exp_q.push_back(s_data_i[c*DW_OUT +: DW_OUT]);
                end
                words_sent++;
            end
            step();
            if (in_x) s_valid_i = 1'b0;
            cycles++;
        end
        chk("rand_words_sent", 64'(words_sent), 64'(N_RAND));
        chk("rand_outputs", 64'(outs_seen), 64'(N_RAND * SCALE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
